idle_pipe_elastic: RTL and testbench

- Parametrised successor to the single-register product hold stage in the HCORDIC datapath.
- A DEPTH-stage, WIDTH-bit elastic delay line with a valid/ready handshake on both sides.
- Idle stages collapse, so the pipe absorbs downstream stalls without dropping or duplicating words.
- Adds a synchronous flush and an occupancy count, so the CORDIC control FSM can drain or abort a rotation in flight.

---
 rtl/idle_pipe_elastic.sv | 106 ++++++++++
 tb/tb_idle_pipe_elastic.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/idle_pipe_elastic.sv
// idle_pipe_elastic: DEPTH-stage, WIDTH-bit elastic delay line with a
// valid/ready handshake on both sides. Empty stages collapse so the pipe
// keeps accepting words while the consumer stalls, until every stage holds one.
// A synchronous flush drops everything in flight, and an occupancy count
// tracks how many stages currently hold a word.

module idle_pipe_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    // Per-stage valid bits and data words, gathered from the stage blocks below
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    // load[i]: stage i may capture a new word this edge.
    // move[i]: stage i hands its word onward this edge.
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] move;

    logic             accept;
    logic             emit;
    logic [CNT_W-1:0] count;

    // A stage can load when the consumer is taking the last word or when any
    // stage from it to the output end is empty, because everything between
    // that hole and the stage shifts forward by one. Writing it as a reduction
    // over the valid bits keeps the ready chain free of self-referencing bits.
    for (genvar i = 0; i < DEPTH; i++) begin : g_load
        assign load[i] = out_ready | ~(&v[DEPTH-1:i]);
    end

    for (genvar i = 0; i < DEPTH - 1; i++) begin : g_move
        assign move[i] = v[i] & load[i+1];
    end

    assign move[DEPTH-1] = v[DEPTH-1] & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             vq;
        logic [WIDTH-1:0] dq;
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = move[i-1];
            assign up_data  = d[i-1];
        end

        // Stage register: take the upstream word when allowed. Data updates
        // only on a real transfer, so bubbles never disturb the held word.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                vq <= 1'b0;
                dq <= '0;
            end else if (flush) begin
                vq <= 1'b0;
            end else if (load[i]) begin
                vq <= up_valid;
                if (up_valid) begin
                    dq <= up_data;
                end
            end
        end

        assign v[i] = vq;
        assign d[i] = dq;
    end

    assign in_ready  = load[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    assign accept = in_valid & in_ready;
    assign emit   = move[DEPTH-1];

    // Occupancy: plus one per accepted word, minus one per delivered word,
    // cleared by flush. A delivery in the flush cycle still counts as done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(accept) - CNT_W'(emit);
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_idle_pipe_elastic.sv
// tb_idle_pipe_elastic: drives DEPTH=1, 2 and 3 copies of the elastic pipe
// with one shared stimulus stream. Each copy has its own reference queue.
// A word's expected presentation cycle is
// max(accept cycle + DEPTH, previous word's departure cycle + 1).

module tb_idle_pipe_elastic;

    localparam int NDUT = 3;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [31:0] in_data   = '0;
    logic        out_ready = 1'b0;

    logic        out_valid_a [NDUT];
    logic        in_ready_a  [NDUT];
    logic [31:0] out_data_a  [NDUT];
    logic [3:0]  occ_a       [NDUT];

    // Instance k has DEPTH = k + 1
    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int D = k + 1;
        logic [$clog2(D+1)-1:0] occ;
        logic                   ov;
        logic                   ir;
        logic [31:0]            od;

        idle_pipe_elastic #(.WIDTH(32), .DEPTH(D)) dut (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_data   (in_data),
            .in_ready  (ir),
            .out_valid (ov),
            .out_data  (od),
            .out_ready (out_ready),
            .occupancy (occ)
        );

        assign out_valid_a[k] = ov;
        assign in_ready_a[k]  = ir;
        assign out_data_a[k]  = od;
        assign occ_a[k]       = 4'(occ);
    end

    always #5 clock = ~clock;

    int cyc = 0;

    // Cycle index, bumped at every rising edge
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state, one entry per instance
    logic [31:0] data_q [NDUT][$];
    int          rdy_q  [NDUT][$];
    int          head_floor [NDUT];
    logic [31:0] last_shown [NDUT];
    logic        accept_ok  [NDUT];

    int total_checks = 0;
    int bad_checks   = 0;

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s depth=%0d t=%0t got=%h want=%h",
                     name, k + 1, $time, actual, expected);
        end
    endtask

    // Monitor: on an async reset rise, check the cleared outputs and empty the
    // model. On every falling edge, compare against the model, pop on each
    // real output transfer, and note which instances should accept this cycle.
    initial begin : monitor
        logic prev_rst;
        logic exp_valid;
        logic exp_ready;
        prev_rst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            head_floor[k] = 0;
            last_shown[k] = '0;
            accept_ok[k]  = 1'b0;
        end
        forever begin
            @(negedge clock or posedge reset);
            if (reset && !prev_rst) begin
                prev_rst = 1'b1;
                #1;
                for (int k = 0; k < NDUT; k++) begin
                    data_q[k].delete();
                    rdy_q[k].delete();
                    head_floor[k] = 0;
                    last_shown[k] = '0;
                    accept_ok[k]  = 1'b0;
                    checkOutput("reset_out_valid", k, 32'(out_valid_a[k]), 32'd0);
                    checkOutput("reset_out_data",  k, out_data_a[k],       32'd0);
                    checkOutput("reset_occupancy", k, 32'(occ_a[k]),       32'd0);
                end
            end else begin
                prev_rst = reset;
                for (int k = 0; k < NDUT; k++) begin
                    exp_valid = (data_q[k].size() > 0) && (rdy_q[k][0] <= cyc)
                                && (head_floor[k] <= cyc);
                    if (exp_valid) last_shown[k] = data_q[k][0];
                    exp_ready = !flush && ((data_q[k].size() < k + 1) || out_ready);
                    checkOutput("out_valid", k, 32'(out_valid_a[k]), 32'(exp_valid));
                    checkOutput("in_ready",  k, 32'(in_ready_a[k]),  32'(exp_ready));
                    checkOutput("occupancy", k, 32'(occ_a[k]),       32'(data_q[k].size()));
                    checkOutput("out_data",  k, out_data_a[k],       last_shown[k]);
                    if (out_valid_a[k] && out_ready) begin
                        if (data_q[k].size() == 0) begin
                            total_checks++;
                            bad_checks++;
                            $display("[TB] FAIL spurious_word depth=%0d t=%0t got=%h want=none",
                                     k + 1, $time, out_data_a[k]);
                        end else begin
                            checkOutput("fifo_order", k, out_data_a[k], data_q[k].pop_front());
                            void'(rdy_q[k].pop_front());
                            head_floor[k] = cyc + 1;
                        end
                    end
                    if (flush) begin
                        data_q[k].delete();
                        rdy_q[k].delete();
                    end
                    accept_ok[k] = exp_ready && !reset;
                end
            end
        end
    end

    // Drive one cycle of inputs, then push every word the model says is accepted
    task automatic applyStimulus(input logic iv, input logic [31:0] dat,
                                 input logic ordy, input logic fl);
        @(posedge clock);
        #1;
        in_valid  = iv;
        in_data   = dat;
        out_ready = ordy;
        flush     = fl;
        @(negedge clock);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (in_valid && accept_ok[k]) begin
                data_q[k].push_back(in_data);
                rdy_q[k].push_back(cyc + k + 1);
            end
        end
    endtask

    // Assert reset asynchronously partway through a cycle, hold it, then release
    task automatic resetMidCycle();
        @(posedge clock);
        #3;
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin : driver
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;

        $display("[TB] streaming 1..8");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

        $display("[TB] backpressure and bubble collapse");
        applyStimulus(1'b1, 32'h0000000A, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0,        1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000000B, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 32'h0000000C, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] full pipe, simultaneous accept and emit");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] flush mid-stream");
        applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h33, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        end
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] async reset with pipe full");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hC0DE0000 + 32'(i), 1'b0, 1'b0);
        resetMidCycle();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'hBEEF0000 + 32'(i), 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
